// File: rtl/exc_pkg.sv
// Shared exception definitions for the EPC stack: MIPS cause encodings and
// default handler vector layout.
package exc_pkg;

   typedef enum logic [2:0] {
      EXC_INT  = 3'd0,
      EXC_ADEL = 3'd1,
      EXC_ADES = 3'd2,
      EXC_SYS  = 3'd3,
      EXC_BP   = 3'd4,
      EXC_RI   = 3'd5,
      EXC_OV   = 3'd6,
      EXC_TR   = 3'd7
   } exc_cause_e;

   localparam logic [31:0] EXC_VECTOR_BASE   = 32'h0000_0180;
   localparam logic [31:0] EXC_VECTOR_STRIDE = 32'h0000_0020;
   localparam logic [31:0] EXC_BD_ADJUST     = 32'h0000_0004;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over the pending exception cause lines.
module exc_prio_enc
   import exc_pkg::*;
#(
   parameter int NUM_CAUSES = 8,
   parameter int CAUSE_W    = $clog2(NUM_CAUSES)
) (
   input  logic [NUM_CAUSES-1:0] req_i,
   output logic                  any_o,
   output logic [CAUSE_W-1:0]    idx_o
);

   assign any_o = |req_i;

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx_o = CAUSE_W'(0);
      for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = CAUSE_W'(i);
         end else begin
            idx_o = idx_o;
         end
      end
   end

endmodule

// File: rtl/exc_epc_stack.sv
// Nested EPC/Cause stack with registered handler/return redirect pulses.
// Optional macro EPC_BDSLOT_EN: save Exc_PC - 4 for faults in a delay slot.
module exc_epc_stack
   import exc_pkg::*;
#(
   parameter int               WIDTH         = 32,
   parameter int               DEPTH         = 4,
   parameter int               NUM_CAUSES    = 8,
   parameter logic [WIDTH-1:0] VECTOR_BASE   = WIDTH'(EXC_VECTOR_BASE),
   parameter logic [WIDTH-1:0] VECTOR_STRIDE = WIDTH'(EXC_VECTOR_STRIDE)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_CAUSES-1:0]         Exc_Req,
   input  logic [WIDTH-1:0]              Exc_PC,
   input  logic                          Exc_BD,
   input  logic                          Eret,
   output logic [WIDTH-1:0]              EPC,
   output logic [$clog2(NUM_CAUSES)-1:0] Cause,
   output logic [$clog2(DEPTH):0]        Level,
   output logic                          Handler_Valid,
   output logic [WIDTH-1:0]              Handler_PC,
   output logic                          Ret_Valid,
   output logic [WIDTH-1:0]              Ret_PC,
   output logic                          Overflow,
   output logic                          Underflow
);

   localparam int CAUSE_W = $clog2(NUM_CAUSES);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;

   logic [WIDTH-1:0]   pc_q [DEPTH];
   logic [WIDTH-1:0]   pc_d [DEPTH];
   logic [CAUSE_W-1:0] cs_q [DEPTH];
   logic [CAUSE_W-1:0] cs_d [DEPTH];
   logic [LVL_W-1:0]   level_q, level_d;
   logic [WIDTH-1:0]   epc_q, epc_d, hpc_q, hpc_d, rpc_q, rpc_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               hv_q, hv_d, rv_q, rv_d, ovf_q, ovf_d, udf_q, udf_d;

   logic               any_s;
   logic [CAUSE_W-1:0] idx_s;
   logic [WIDTH-1:0]   saved_pc_s;
   logic [PTR_W-1:0]   top_s, below_s, push_s;
   logic               full_s, empty_s;

   exc_prio_enc #(.NUM_CAUSES(NUM_CAUSES), .CAUSE_W(CAUSE_W)) u_prio (
      .req_i (Exc_Req),
      .any_o (any_s),
      .idx_o (idx_s)
   );

`ifdef EPC_BDSLOT_EN
   assign saved_pc_s = Exc_BD ? (Exc_PC - WIDTH'(EXC_BD_ADJUST)) : Exc_PC;
`else
   logic unused_bd_s;
   assign unused_bd_s = Exc_BD;
   assign saved_pc_s  = Exc_PC;
`endif

   assign top_s   = PTR_W'(level_q - LVL_W'(1));
   assign below_s = PTR_W'(level_q - LVL_W'(2));
   assign push_s  = level_q[PTR_W-1:0];
   assign full_s  = (level_q == LVL_W'(DEPTH));
   assign empty_s = (level_q == LVL_W'(0));

   // Next-state: an exception outranks a same-cycle ERET, which then only retargets the top entry.
   always_comb begin
      pc_d    = pc_q;
      cs_d    = cs_q;
      level_d = level_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      hv_d    = 1'b0;
      hpc_d   = hpc_q;
      rv_d    = 1'b0;
      rpc_d   = rpc_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (any_s) begin
         hv_d  = 1'b1;
         hpc_d = VECTOR_BASE + WIDTH'(idx_s) * VECTOR_STRIDE;
         if (Eret && !empty_s) begin
            pc_d[top_s] = saved_pc_s;
            cs_d[top_s] = idx_s;
            epc_d       = saved_pc_s;
            cause_d     = idx_s;
         end else if (full_s) begin
            ovf_d = 1'b1;
         end else begin
            pc_d[push_s] = saved_pc_s;
            cs_d[push_s] = idx_s;
            level_d      = level_q + LVL_W'(1);
            epc_d        = saved_pc_s;
            cause_d      = idx_s;
         end
      end else if (Eret) begin
         if (!empty_s) begin
            rv_d    = 1'b1;
            rpc_d   = pc_q[top_s];
            level_d = level_q - LVL_W'(1);
            if (level_q == LVL_W'(1)) begin
               epc_d   = WIDTH'(0);
               cause_d = CAUSE_W'(0);
            end else begin
               epc_d   = pc_q[below_s];
               cause_d = cs_q[below_s];
            end
         end else begin
            udf_d = 1'b1;
         end
      end else begin
         level_d = level_q;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i] <= WIDTH'(0);
            cs_q[i] <= CAUSE_W'(0);
         end
         level_q <= LVL_W'(0);
         epc_q   <= WIDTH'(0);
         cause_q <= CAUSE_W'(0);
         hv_q    <= 1'b0;
         hpc_q   <= WIDTH'(0);
         rv_q    <= 1'b0;
         rpc_q   <= WIDTH'(0);
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         cs_q    <= cs_d;
         level_q <= level_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         hv_q    <= hv_d;
         hpc_q   <= hpc_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign EPC           = epc_q;
   assign Cause         = cause_q;
   assign Level         = level_q;
   assign Handler_Valid = hv_q;
   assign Handler_PC    = hpc_q;
   assign Ret_Valid     = rv_q;
   assign Ret_PC        = rpc_q;
   assign Overflow      = ovf_q;
   assign Underflow     = udf_q;

endmodule

// File: tb/tb_exc_epc_stack.sv
// Self-checking bench for exc_epc_stack against a queue-based reference model.
module tb_exc_epc_stack;
   import exc_pkg::*;

`ifdef EPC_BDSLOT_EN
   localparam bit BD_EN = 1'b1;
`else
   localparam bit BD_EN = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  Exc_Req;
   logic [31:0] Exc_PC;
   logic        Exc_BD, Eret;
   logic [31:0] EPC, Handler_PC, Ret_PC;
   logic [2:0]  Cause, Level;
   logic        Handler_Valid, Ret_Valid, Overflow, Underflow;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] q_pc[$];
   logic [2:0]  q_cs[$];
   logic        m_hv, m_rv, m_ovf, m_udf;
   logic [31:0] m_hpc, m_rpc;

   exc_epc_stack dut (
      .CLK(CLK), .RST(RST), .Exc_Req(Exc_Req), .Exc_PC(Exc_PC), .Exc_BD(Exc_BD),
      .Eret(Eret), .EPC(EPC), .Cause(Cause), .Level(Level),
      .Handler_Valid(Handler_Valid), .Handler_PC(Handler_PC),
      .Ret_Valid(Ret_Valid), .Ret_PC(Ret_PC),
      .Overflow(Overflow), .Underflow(Underflow)
   );

   always #5 CLK = ~CLK;

   function automatic void model_reset();
      q_pc.delete();
      q_cs.delete();
      m_hv = 1'b0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      m_hpc = 32'h0; m_rpc = 32'h0;
   endfunction

   function automatic void model_step(input logic [7:0] req, input logic [31:0] pc,
                                      input logic bd, input logic er);
      int c;
      logic [31:0] sv;
      m_hv = 1'b0;
      m_rv = 1'b0;
      if (req != 8'h0) begin
         c = 0;
         for (int i = 7; i >= 0; i--) if (req[i]) c = i;
         sv = (BD_EN && bd) ? pc - 32'd4 : pc;
         m_hv  = 1'b1;
         m_hpc = 32'h180 + 32'(c) * 32'h20;
         if (er && q_pc.size() > 0) begin
            q_pc[q_pc.size()-1] = sv;
            q_cs[q_cs.size()-1] = 3'(c);
         end else if (q_pc.size() == DEPTH) begin
            m_ovf = 1'b1;
         end else begin
            q_pc.push_back(sv);
            q_cs.push_back(3'(c));
         end
      end else if (er) begin
         if (q_pc.size() > 0) begin
            m_rpc = q_pc.pop_back();
            void'(q_cs.pop_back());
            m_rv  = 1'b1;
         end else begin
            m_udf = 1'b1;
         end
      end
   endfunction

   function automatic logic [31:0] m_epc();
      return (q_pc.size() > 0) ? q_pc[q_pc.size()-1] : 32'h0;
   endfunction

   function automatic logic [2:0] m_cause();
      return (q_cs.size() > 0) ? q_cs[q_cs.size()-1] : 3'h0;
   endfunction

   task automatic drive(input logic [7:0] req, input logic [31:0] pc,
                        input logic bd, input logic er);
      Exc_Req = req; Exc_PC = pc; Exc_BD = bd; Eret = er;
      @(posedge CLK);
      model_step(req, pc, bd, er);
      #1;
      Exc_Req = 8'h0; Exc_PC = 32'h0; Exc_BD = 1'b0; Eret = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         Exc_Req = 8'($urandom); Exc_PC = $urandom; Exc_BD = 1'($urandom); Eret = 1'($urandom);
         @(posedge CLK);
         #1;
      end
      n_chk++; if (Level !== 3'd0)        begin n_fail++; $display("FAIL rst_level got %0d exp 0", Level); end
      n_chk++; if (EPC !== 32'h0)         begin n_fail++; $display("FAIL rst_epc got %h exp 0", EPC); end
      n_chk++; if (Cause !== 3'd0)        begin n_fail++; $display("FAIL rst_cause got %0d exp 0", Cause); end
      n_chk++; if (Handler_Valid !== 1'b0 || Ret_Valid !== 1'b0)
         begin n_fail++; $display("FAIL rst_pulses got hv=%b rv=%b exp 0", Handler_Valid, Ret_Valid); end
      n_chk++; if (Handler_PC !== 32'h0 || Ret_PC !== 32'h0)
         begin n_fail++; $display("FAIL rst_pcs got hpc=%h rpc=%h exp 0", Handler_PC, Ret_PC); end
      n_chk++; if (Overflow !== 1'b0 || Underflow !== 1'b0)
         begin n_fail++; $display("FAIL rst_flags got ov=%b un=%b exp 0", Overflow, Underflow); end
      Exc_Req = 8'h0; Exc_PC = 32'h0; Exc_BD = 1'b0; Eret = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      n_chk++; if (Level !== 3'd0 || Handler_Valid !== 1'b0 || EPC !== 32'h0)
         begin n_fail++; $display("FAIL rst_idle got lvl=%0d hv=%b epc=%h exp 0", Level, Handler_Valid, EPC); end
      // Asynchronous reset in the middle of a cycle with live state.
      drive(8'h01, 32'h111, 1'b0, 1'b0);
      drive(8'h02, 32'h222, 1'b0, 1'b0);
      #2 RST = 1'b0;
      #1;
      model_reset();
      n_chk++; if (Level !== 3'd0 || EPC !== 32'h0 || Handler_Valid !== 1'b0 || Handler_PC !== 32'h0)
         begin n_fail++; $display("FAIL rst_async got lvl=%0d epc=%h hv=%b hpc=%h exp 0", Level, EPC, Handler_Valid, Handler_PC); end
      @(posedge CLK);
      #1 RST = 1'b1;
   endtask

   task automatic test_priority();
      drive(8'b0010_0100, 32'h400, 1'b0, 1'b0);
      n_chk++; if (EPC !== 32'h400)  begin n_fail++; $display("FAIL prio_epc got %h exp 400", EPC); end
      n_chk++; if (Cause !== 3'd2)   begin n_fail++; $display("FAIL prio_cause got %0d exp 2", Cause); end
      n_chk++; if (Level !== 3'd1)   begin n_fail++; $display("FAIL prio_level got %0d exp 1", Level); end
      n_chk++; if (Handler_Valid !== 1'b1 || Handler_PC !== 32'h1C0)
         begin n_fail++; $display("FAIL prio_handler got hv=%b hpc=%h exp 1/1c0", Handler_Valid, Handler_PC); end
      drive(8'h0, 32'h0, 1'b0, 1'b0);
      n_chk++; if (Handler_Valid !== 1'b0 || Handler_PC !== 32'h1C0)
         begin n_fail++; $display("FAIL prio_hold got hv=%b hpc=%h exp 0/1c0", Handler_Valid, Handler_PC); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_nesting();
      for (int i = 1; i <= 4; i++) begin
         drive(8'h08, 32'(i) * 32'h100, 1'b0, 1'b0);
         n_chk++; if (Level !== 3'(i) || Handler_Valid !== 1'b1)
            begin n_fail++; $display("FAIL nest_push%0d got lvl=%0d hv=%b exp %0d/1", i, Level, Handler_Valid, i); end
      end
      for (int i = 4; i >= 1; i--) begin
         drive(8'h0, 32'h0, 1'b0, 1'b1);
         n_chk++; if (Ret_Valid !== 1'b1 || Ret_PC !== 32'(i) * 32'h100 || Handler_Valid !== 1'b0)
            begin n_fail++; $display("FAIL nest_pop%0d got rv=%b rpc=%h hv=%b exp 1/%h/0", i, Ret_Valid, Ret_PC, Handler_Valid, 32'(i) * 32'h100); end
         n_chk++; if (EPC !== m_epc())
            begin n_fail++; $display("FAIL nest_epc%0d got %h exp %h", i, EPC, m_epc()); end
      end
      n_chk++; if (Level !== 3'd0) begin n_fail++; $display("FAIL nest_empty got %0d exp 0", Level); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
      n_chk++; if (Underflow !== 1'b1 || Ret_Valid !== 1'b0 || Level !== 3'd0)
         begin n_fail++; $display("FAIL nest_underflow got un=%b rv=%b lvl=%0d exp 1/0/0", Underflow, Ret_Valid, Level); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         drive(8'h40, 32'(i) * 32'h1000, 1'b0, 1'b0);
         n_chk++; if (Handler_Valid !== 1'b1 || Handler_PC !== 32'h240)
            begin n_fail++; $display("FAIL ovf_hv%0d got hv=%b hpc=%h exp 1/240", i, Handler_Valid, Handler_PC); end
         n_chk++; if (Overflow !== (i == 5))
            begin n_fail++; $display("FAIL ovf_flag%0d got %b exp %b", i, Overflow, (i == 5)); end
      end
      n_chk++; if (Level !== 3'd4 || EPC !== 32'h4000)
         begin n_fail++; $display("FAIL ovf_state got lvl=%0d epc=%h exp 4/4000", Level, EPC); end
      for (int i = 0; i < 4; i++) drive(8'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_simultaneous();
      drive(8'h01, 32'h100, 1'b0, 1'b0);
      drive(8'h01, 32'h200, 1'b0, 1'b0);
      drive(8'h01, 32'h500, 1'b0, 1'b1);
      n_chk++; if (Level !== 3'd2 || EPC !== 32'h500)
         begin n_fail++; $display("FAIL simul_state got lvl=%0d epc=%h exp 2/500", Level, EPC); end
      n_chk++; if (Handler_Valid !== 1'b1 || Ret_Valid !== 1'b0)
         begin n_fail++; $display("FAIL simul_pulses got hv=%b rv=%b exp 1/0", Handler_Valid, Ret_Valid); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
      n_chk++; if (Ret_PC !== 32'h500 || EPC !== 32'h100)
         begin n_fail++; $display("FAIL simul_pop got rpc=%h epc=%h exp 500/100", Ret_PC, EPC); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_delay_slot();
      drive(8'h10, 32'h404, 1'b1, 1'b0);
      n_chk++; if (EPC !== (BD_EN ? 32'h400 : 32'h404))
         begin n_fail++; $display("FAIL bdslot_epc got %h exp %h", EPC, (BD_EN ? 32'h400 : 32'h404)); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      drive(8'h02, 32'h10, 1'b0, 1'b0);
      n_chk++; if (Handler_Valid !== 1'b1 || Handler_PC !== 32'h1A0)
         begin n_fail++; $display("FAIL b2b_first got hv=%b hpc=%h exp 1/1a0", Handler_Valid, Handler_PC); end
      drive(8'h80, 32'h20, 1'b0, 1'b0);
      n_chk++; if (Handler_Valid !== 1'b1 || Handler_PC !== 32'h260 || Level !== 3'd2 || Cause !== 3'd7)
         begin n_fail++; $display("FAIL b2b_second got hv=%b hpc=%h lvl=%0d cause=%0d exp 1/260/2/7", Handler_Valid, Handler_PC, Level, Cause); end
      drive(8'h0, 32'h0, 1'b0, 1'b1);
      drive(8'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] req;
      RST = 1'b0;
      #1;
      model_reset();
      @(posedge CLK);
      #1 RST = 1'b1;
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 3))
            0:       req = 8'($urandom);
            1:       req = 8'h1 << $urandom_range(0, 7);
            default: req = 8'h0;
         endcase
         drive(req, $urandom & 32'hFFFF_FFFC, 1'($urandom), ($urandom_range(0, 9) < 5));
         n_chk++; if (Level !== 3'(q_pc.size()) || EPC !== m_epc() || Cause !== m_cause())
            begin n_fail++; $display("FAIL rnd_top[%0d] got lvl=%0d epc=%h cause=%0d exp %0d/%h/%0d", k, Level, EPC, Cause, q_pc.size(), m_epc(), m_cause()); end
         n_chk++; if (Handler_Valid !== m_hv || Handler_PC !== m_hpc)
            begin n_fail++; $display("FAIL rnd_handler[%0d] got %b/%h exp %b/%h", k, Handler_Valid, Handler_PC, m_hv, m_hpc); end
         n_chk++; if (Ret_Valid !== m_rv || Ret_PC !== m_rpc)
            begin n_fail++; $display("FAIL rnd_ret[%0d] got %b/%h exp %b/%h", k, Ret_Valid, Ret_PC, m_rv, m_rpc); end
         n_chk++; if (Overflow !== m_ovf || Underflow !== m_udf || (Handler_Valid && Ret_Valid))
            begin n_fail++; $display("FAIL rnd_flags[%0d] got ov=%b un=%b hv=%b rv=%b exp ov=%b un=%b", k, Overflow, Underflow, Handler_Valid, Ret_Valid, m_ovf, m_udf); end
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_nesting();
      test_overflow();
      test_simultaneous();
      test_delay_slot();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_epc_stack.md
# exc_epc_stack

Parametrised exception-PC unit for the pipelined MIPS core: a nested EPC/Cause stack that replaces the single-entry EPC register. It priority-encodes a vector of pending exception causes, pushes the faulting PC and cause on exception, pops on ERET, and issues registered one-cycle redirect pulses (handler vector or return PC) to the fetch stage. It sits beside the control unit, fed from the stage that commits exceptions.

## Interface
- WIDTH, 32: PC/EPC width in bits.
- DEPTH, 4: nesting depth (stack entries), power of two, ≥2.
- NUM_CAUSES, 8: number of cause request lines; CAUSE_W = $clog2(NUM_CAUSES).
- VECTOR_BASE, 32'h0000_0180: handler base address.
- VECTOR_STRIDE, 32'h0000_0020: byte spacing between per-cause handlers.
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Exc_Req  input  NUM_CAUSES  pending exception causes; bit 0 is highest priority.
- Exc_PC  input  WIDTH  PC of the faulting instruction.
- Exc_BD  input  1  faulting instruction is in a branch delay slot.
- Eret  input  1  ERET committed this cycle.
- EPC  output  WIDTH  PC at stack top; 0 when empty.
- Cause  output  CAUSE_W  cause at stack top; 0 when empty.
- Level  output  $clog2(DEPTH)+1  current stack occupancy.
- Handler_Valid  output  1  one-cycle pulse: redirect fetch to Handler_PC.
- Handler_PC  output  WIDTH  VECTOR_BASE + cause × VECTOR_STRIDE.
- Ret_Valid  output  1  one-cycle pulse: redirect fetch to Ret_PC.
- Ret_PC  output  WIDTH  EPC popped by ERET.
- Overflow  output  1  sticky: exception taken while stack full.
- Underflow  output  1  sticky: ERET with stack empty.

## Operation
- Exception taken when |Exc_Req; cause = index of lowest set bit.
- Saved PC = Exc_PC, or Exc_PC − 4 when Exc_BD and EPC_BDSLOT_EN is defined (modulo 2^WIDTH).
- Exception, not full: push {PC, cause}; Level+1; Handler_Valid pulse.
- Exception, full: no push; stack unchanged; Overflow set; Handler_Valid still pulses (handler runs without a saved return).
- ERET, not empty: pop; Ret_PC = popped PC; Ret_Valid pulse; Level−1.
- ERET, empty: no change; Underflow set; no Ret_Valid.
- Exception and ERET in the same cycle: exception wins; ERET is discarded. If Level>0, the top entry is replaced in place (Level unchanged, Overflow not set); if Level=0, a normal push. Only Handler_Valid pulses.
- Handler_Valid and Ret_Valid are never high together.
- Overflow and Underflow clear only on reset.
- Reset state: Level=0; all stack entries, EPC, Cause, Handler_PC and Ret_PC are 0; every pulse and flag is 0.
- Reset mid-operation clears everything immediately (asynchronous). Pending requests on the first edge after release are honoured.

## Timing
- All outputs are registered. Inputs sampled at edge N appear after edge N: EPC, Cause and Level updated, and pulses high for exactly cycle N+1.
- Handler_PC and Ret_PC hold their last value when the pulses are low.
- Back-to-back exceptions on consecutive cycles each push. Handler_Valid is high for two consecutive cycles, each with its own Handler_PC.
- Throughput is one event per cycle; the block never stalls.

## Configuration
- EPC_BDSLOT_EN defined: branch-delay correction (PC − 4) is applied when Exc_BD=1.
- EPC_BDSLOT_EN not defined: Exc_BD is ignored and Exc_PC is always saved unmodified.

## Structure
- Shared package exc_pkg: cause encodings (INT, ADEL, ADES, SYS, BP, RI, OV, TR), default VECTOR_BASE/VECTOR_STRIDE.
- Sub-module exc_prio_enc: combinational lowest-index priority encoder, parametrised by NUM_CAUSES, with any/index outputs.
- Stack: register array plus level pointer.

## Test plan
- Reset: hold RST=0 with random inputs → every output 0. Release RST → still 0 until the first event.
- Priority: Exc_Req=8'b0010_0100, Exc_PC=32'h400 → next cycle EPC=32'h400, Cause=2, Level=1, Handler_Valid=1, Handler_PC=32'h1C0.
- Nesting: 4 exceptions at PCs 0x100/0x200/0x300/0x400, then 4 ERETs → Ret_PC pulses 0x400, 0x300, 0x200, 0x100; Level returns to 0; a 5th ERET sets Underflow with no Ret_Valid.
- Overflow: 5 exceptions at DEPTH=4 → Level stays 4, Overflow=1, EPC = 4th PC, Handler_Valid pulses on all 5.
- Simultaneous: Level=2 (top 0x200), then Exc_Req=1 with Exc_PC=0x500 and Eret=1 → Level=2, EPC=0x500, Handler_Valid=1, Ret_Valid=0.
- Delay slot: Exc_BD=1, Exc_PC=0x404 → EPC=0x400 with EPC_BDSLOT_EN defined; EPC=0x404 without it.
